cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit combinational ripple-of-CLA-blocks adder.
- Splits a WIDTH-bit operation into WIDTH/BLK lookahead slices, one slice per pipeline stage, with registered inter-slice carries and a valid/ready handshake.
- Serves as the datapath adder for the ALU and accumulator blocks: one operation per cycle, backpressure from the consumer.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of BLK and >= BLK.
- BLK, 4, bits per CLA slice (group P/G computed per slice); pipeline depth L = WIDTH/BLK.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/mode present
- in_ready  out  1  stage 0 can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in (ignored when sub=1)
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum/difference
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB
- grp_p  out  WIDTH/BLK  per-slice group propagate of the reported result
- grp_g  out  WIDTH/BLK  per-slice group generate of the reported result

Behaviour:
- Reset (async, rst=1): all stage valid flags = 0; out_valid=0, s=0, cout=0, ovf=0, grp_p=0, grp_g=0. in_ready=1 once rst deasserts. Reset mid-operation discards all in-flight results; none is emitted afterwards.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Pipeline advance: adv = !(out_valid && !out_ready). When adv=0, every stage holds its contents. in_ready = adv, combinational from out_valid/out_ready only and never from in_valid.
- Stage 0 (on input transfer): registers b_eff = sub ? ~b : b and c0 = sub ? 1 : cin. Computes slice 0 (bits BLK-1:0) with a BLK-bit lookahead: p=a^b_eff, g=a&b_eff, carries from p/g only, no internal ripple. Registers slice sum, slice carry-out, group P/G, and the remaining unprocessed operand bits.
- Stage k (1..L-1): computes bits [k*BLK +: BLK] from carry register k-1. Completed lower sum bits and upper operand bits travel through skew registers.
- Last stage: drives s, cout and ovf. ovf uses the carry into bit WIDTH-1, taken from inside the last slice.
- Latency: result for an input accepted at edge t is out_valid at edge t+L, with no stalls. Stalls add cycles one for one.
- Throughput: 1 operation/cycle; results emerge in acceptance order, none dropped or duplicated.
- Bubbles: an empty stage (valid=0) advances as a bubble; out_valid=0 when the last stage holds a bubble.
- Simultaneous output and input transfer in one cycle is legal and keeps full throughput.
- Width rules: all arithmetic is modulo 2^WIDTH; s never wraps into cout except through the real MSB carry.
- Output hold: while out_valid=1 && out_ready=0, s/cout/ovf/grp_p/grp_g stay stable.
- Output contents when out_valid=0: don't-care to the consumer, but must not be X after reset.

Optional Feature:
- Macro: CLA_ADDSUB_SAT_EN.
- Defined: s saturates on signed overflow (ovf=1) to 2^(WIDTH-1)-1 when the true result is positive, and to 2^(WIDTH-1) (most negative) when negative. Sign is taken from operand A's MSB. ovf still reports 1; cout is unchanged.
- Undefined: s is the wrapped modulo result; no extra logic.

Test Plan (WIDTH=16, BLK=4, L=4):
- Add, no carry: a=414, b=1036, cin=0, sub=0, out_ready=1 -> s=1450, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
- Back-to-back stream: (5045,45042), (32768,32768), (65535,65535) on consecutive cycles. Required results in order:
  - s=50087, cout=0, ovf=0
  - s=0, cout=1, ovf=1 (SAT_EN: s=32768)
  - s=65534, cout=1, ovf=0
  - one result per cycle.
- Subtract: a=1036, b=414, sub=1 -> s=622, cout=1, ovf=0. Then a=414, b=1036, sub=1 -> s=64914, cout=0, ovf=0.
- Backpressure: stream 6 ops with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 6 results correct and in order, none lost.
- Reset mid-flight: assert rst with 3 ops in flight -> out_valid=0 immediately (async), no stale result after release. Next op a=32767, b=1 -> s=32768, ovf=1 (SAT_EN: s=32767).
- Carry across every slice: a=65535, b=0, cin=1 -> s=0, cout=1, grp_p=4'b1111, grp_g=4'b0000.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit lookahead slice per stage, valid/ready handshake.
// Optional macro CLA_ADDSUB_SAT_EN: saturate s on signed overflow instead of wrapping.

module cla_slice #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] sum,
    output logic           co,
    output logic           gp,
    output logic           gg,
    output logic           cmsb
);
    logic [BLK-1:0] p, g;
    logic [BLK:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a flat sum-of-products over p/g/ci; no carry feeds another.
    always_comb begin
        logic acc;
        logic term;
        c    = '0;
        gg   = 1'b0;
        acc  = 1'b0;
        term = 1'b0;
        for (int i = 0; i <= BLK; i++) begin
            acc = ci;
            for (int m = 0; m < i; m++) acc = acc & p[m];
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                acc = acc | term;
            end
            c[i] = acc;
        end
        for (int j = 0; j < BLK; j++) begin
            term = g[j];
            for (int m = j + 1; m < BLK; m++) term = term & p[m];
            gg = gg | term;
        end
    end

    assign gp   = &p;
    assign co   = c[BLK];
    assign cmsb = c[BLK-1];
    assign sum  = p ^ c[BLK-1:0];
endmodule

module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     s,
    output logic                 cout,
    output logic                 ovf,
    output logic [WIDTH/BLK-1:0] grp_p,
    output logic [WIDTH/BLK-1:0] grp_g
);
    localparam int L = WIDTH / BLK;

    // Rank k holds operands and the sum of slices 0..k-1; rank L is the output register.
    logic [L:0]            vld_pipe;
    logic [L-1:0][WIDTH-1:0] a_r, b_r;
    logic [L:0][WIDTH-1:0] s_r;
    logic [L:0]            c_r;
    logic [L:0][L-1:0]     gp_r, gg_r;
    logic                  cm_r;

    logic [L-1:0][BLK-1:0] sl_sum;
    logic [L-1:0]          sl_co, sl_gp, sl_gg, sl_cm;
    logic                  adv;
    logic                  ovf_w;
    logic                  unused_bits;

    assign adv      = !(vld_pipe[L] && !out_ready);
    assign in_ready = adv;

    generate
        for (genvar k = 0; k < L; k++) begin : g_slice
            cla_slice #(.BLK(BLK)) u_slice (
                .a    (a_r[k][k*BLK +: BLK]),
                .b    (b_r[k][k*BLK +: BLK]),
                .ci   (c_r[k]),
                .sum  (sl_sum[k]),
                .co   (sl_co[k]),
                .gp   (sl_gp[k]),
                .gg   (sl_gg[k]),
                .cmsb (sl_cm[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a_r      <= '0;
            b_r      <= '0;
            s_r      <= '0;
            c_r      <= '0;
            gp_r     <= '0;
            gg_r     <= '0;
            cm_r     <= 1'b0;
        end else if (adv) begin
            vld_pipe[0] <= in_valid;
            if (in_valid) begin
                a_r[0]  <= a;
                b_r[0]  <= sub ? ~b : b;
                c_r[0]  <= sub | cin;
                s_r[0]  <= '0;
                gp_r[0] <= '0;
                gg_r[0] <= '0;
            end
            for (int k = 0; k < L; k++) begin
                vld_pipe[k+1] <= vld_pipe[k];
                if (vld_pipe[k]) begin
                    if (k + 1 < L) begin
                        a_r[k+1] <= a_r[k];
                        b_r[k+1] <= b_r[k];
                    end
                    s_r[k+1]                <= s_r[k];
                    s_r[k+1][k*BLK +: BLK]  <= sl_sum[k];
                    c_r[k+1]                <= sl_co[k];
                    gp_r[k+1]               <= gp_r[k];
                    gp_r[k+1][k]            <= sl_gp[k];
                    gg_r[k+1]               <= gg_r[k];
                    gg_r[k+1][k]            <= sl_gg[k];
                    if (k == L - 1) cm_r    <= sl_cm[k];
                end
            end
        end
    end

    assign ovf_w     = c_r[L] ^ cm_r;
    assign out_valid = vld_pipe[L];
    assign cout      = c_r[L];
    assign ovf       = ovf_w;
    assign grp_p     = gp_r[L];
    assign grp_g     = gg_r[L];

`ifdef CLA_ADDSUB_SAT_EN
    // On overflow A and the effective B share a sign, which is the inverse of the wrapped MSB.
    always_comb begin
        s = s_r[L];
        if (ovf_w) s = s_r[L][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`else
    assign s = s_r[L];
`endif

    assign unused_bits = ^{a_r[L-1], b_r[L-1], sl_cm};
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: arithmetic reference model plus directed literal vectors.
module tb_cla_addsub_pipe;
    localparam int W = 16;
    localparam int B = 4;
    localparam int L = W / B;

`ifdef CLA_ADDSUB_SAT_EN
    localparam logic [W-1:0] S_NEGOVF = 16'd32768;
    localparam logic [W-1:0] S_POSOVF = 16'd32767;
`else
    localparam logic [W-1:0] S_NEGOVF = 16'd0;
    localparam logic [W-1:0] S_POSOVF = 16'd32768;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         cout, ovf;
    logic [L-1:0] grp_p, grp_g;

    int nchecks = 0;
    int nerr = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic [L-1:0] gp;
        logic [L-1:0] gg;
        bit           lit;
        logic [W-1:0] ls;
        logic         lc;
        logic         lo;
        bit           litg;
        logic [L-1:0] lgp;
        logic [L-1:0] lgg;
    } exp_t;

    exp_t q[$];
    bit           cur_lit = 0, cur_litg = 0;
    logic [W-1:0] cur_ls = '0;
    logic         cur_lc = 0, cur_lo = 0;
    logic [L-1:0] cur_lgp = '0, cur_lgg = '0;

    cla_addsub_pipe #(.WIDTH(W), .BLK(B)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .grp_p(grp_p), .grp_g(grp_g)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Plain integer arithmetic: full-width sum, sign rule for overflow, per-slice all-propagate / slice-generates.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   full;
        logic [B-1:0] as, bs;
        logic [B:0]   part;
        be      = ts ? ~tb : tb;
        full    = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, (ts ? 1'b1 : tc)};
        e.s     = full[W-1:0];
        e.cout  = full[W];
        e.ovf   = (ta[W-1] == be[W-1]) && (e.s[W-1] != ta[W-1]);
`ifdef CLA_ADDSUB_SAT_EN
        if (e.ovf) e.s = ta[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        for (int k = 0; k < L; k++) begin
            as       = ta[k*B +: B];
            bs       = be[k*B +: B];
            part     = {1'b0, as} + {1'b0, bs};
            e.gp[k]  = ((as ^ bs) == {B{1'b1}});
            e.gg[k]  = part[B];
        end
        e.lit  = 0;
        e.ls   = '0;
        e.lc   = 0;
        e.lo   = 0;
        e.litg = 0;
        e.lgp  = '0;
        e.lgg  = '0;
        return e;
    endfunction

    // Compare process: one look per cycle at the falling edge.
    initial begin
        exp_t         e;
        bit           hold;
        logic [W-1:0] ps;
        logic         pc, po;
        logic [L-1:0] pp, pg;
        hold = 0; ps = '0; pc = 0; po = 0; pp = '0; pg = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                hold = 0;
            end else begin
                chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
                if (hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_s", s, ps);
                    chk("hold_cout", cout, pc);
                    chk("hold_ovf", ovf, po);
                    chk("hold_grp_p", grp_p, pp);
                    chk("hold_grp_g", grp_g, pg);
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        nchecks++;
                        nerr++;
                        $display("FAIL spurious_result: got s=%0d, expected no result", s);
                    end else begin
                        e = q[0];
                        chk("s", s, e.s);
                        chk("cout", cout, e.cout);
                        chk("ovf", ovf, e.ovf);
                        chk("grp_p", grp_p, e.gp);
                        chk("grp_g", grp_g, e.gg);
                        if (e.lit) begin
                            chk("lit_s", s, e.ls);
                            chk("lit_cout", cout, e.lc);
                            chk("lit_ovf", ovf, e.lo);
                        end
                        if (e.litg) begin
                            chk("lit_grp_p", grp_p, e.lgp);
                            chk("lit_grp_g", grp_g, e.lgg);
                        end
                        if (out_ready) void'(q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    e      = model(a, b, cin, sub);
                    e.lit  = cur_lit;
                    e.ls   = cur_ls;
                    e.lc   = cur_lc;
                    e.lo   = cur_lo;
                    e.litg = cur_litg;
                    e.lgp  = cur_lgp;
                    e.lgg  = cur_lgg;
                    q.push_back(e);
                end
                hold = out_valid && !out_ready;
                ps = s; pc = cout; po = ovf; pp = grp_p; pg = grp_g;
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts,
                        input bit lit, input logic [W-1:0] ls, input logic lc, input logic lo);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        cur_lit = lit; cur_ls = ls; cur_lc = lc; cur_lo = lo;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        nchecks++;
        nerr++;
        $display("FAIL send_timeout: got no in_ready in 100 cycles, expected acceptance");
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        cur_lit  = 0;
        cur_litg = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_grp_p", grp_p, 0);
        chk("rst_grp_g", grp_g, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);

        // Single add and its latency
        send(16'd414, 16'd1036, 0, 0, 1, 16'd1450, 0, 0);
        idle(0);
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            chk("latency_valid", out_valid, (k == L + 1));
        end
        idle(3);

        // Back-to-back stream
        send(16'd5045, 16'd45042, 0, 0, 1, 16'd50087, 0, 0);
        send(16'd32768, 16'd32768, 0, 0, 1, S_NEGOVF, 1, 1);
        send(16'd65535, 16'd65535, 0, 0, 1, 16'd65534, 1, 0);
        idle(8);

        // Subtract both ways
        send(16'd1036, 16'd414, 0, 1, 1, 16'd622, 1, 0);
        send(16'd414, 16'd1036, 0, 1, 1, 16'd64914, 0, 0);
        idle(8);

        // Backpressure mid-stream
        fork
            begin
                send(16'd1, 16'd2, 0, 0, 0, '0, 0, 0);
                send(16'd40000, 16'd30000, 0, 0, 0, '0, 0, 0);
                send(16'd100, 16'd200, 0, 1, 0, '0, 0, 0);
                send(16'h8000, 16'd1, 0, 1, 0, '0, 0, 0);
                send(16'd12345, 16'd54321, 1, 0, 0, '0, 0, 0);
                send(16'd7, 16'd7, 1, 0, 0, '0, 0, 0);
                idle(0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                #1 chk("stall_in_ready", in_ready, 0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(10);
        chk("bp_drained", q.size(), 0);

        // Reset with results in flight
        send(16'd10, 16'd20, 0, 0, 0, '0, 0, 0);
        send(16'd30, 16'd40, 0, 0, 0, '0, 0, 0);
        send(16'd50, 16'd60, 0, 0, 0, '0, 0, 0);
        idle(2);
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1 chk("async_rst_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(8);
        send(16'd32767, 16'd1, 0, 0, 1, S_POSOVF, 0, 1);
        idle(8);

        // Carry through every slice
        cur_litg = 1;
        cur_lgp  = 4'b1111;
        cur_lgg  = 4'b0000;
        send(16'd65535, 16'd0, 1, 0, 1, 16'd0, 1, 0);
        idle(8);

        chk("final_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
